// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: program-counter source encoding and default address width.
package mips_pkg;

  localparam int ADDR_W_DEFAULT = 32;

  // Code 3'd7 is reserved and treated as sequential by consumers.
  typedef enum logic [2:0] {
    PC_SEQ  = 3'd0,
    PC_BR   = 3'd1,
    PC_J    = 3'd2,
    PC_JR   = 3'd3,
    PC_BN   = 3'd4,
    PC_CALL = 3'd5,
    PC_RET  = 3'd6
  } pc_sel_t;

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack; on overflow the oldest entry is overwritten.
module return_addr_stack #(
  parameter int ADDR_W    = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] top,
  output logic              empty,
  output logic              full,
  output logic              ovf,
  output logic              unf
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] mem_r [RAS_DEPTH];
  // ptr_r is the next write slot; when full it also addresses the oldest entry.
  logic [PTR_W-1:0]  ptr_r;
  logic [PTR_W-1:0]  top_idx_s;
  logic [CNT_W-1:0]  cnt_r;
  logic              empty_s;
  logic              full_s;
  logic              ovf_r;
  logic              unf_r;

  assign top_idx_s = ptr_r - PTR_W'(1'b1);
  assign empty_s   = (cnt_r == {CNT_W{1'b0}});
  assign full_s    = (cnt_r == FULL_CNT);

  assign top   = mem_r[top_idx_s];
  assign empty = empty_s;
  assign full  = full_s;
  assign ovf   = ovf_r;
  assign unf   = unf_r;

  // Entry storage: contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (en && push) begin
      mem_r[ptr_r] <= din;
    end
  end

  // Pointer, occupancy count and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r <= {PTR_W{1'b0}};
      cnt_r <= {CNT_W{1'b0}};
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else if (en) begin
      if (push) begin
        ptr_r <= ptr_r + PTR_W'(1'b1);
        if (full_s) begin
          ovf_r <= 1'b1;
        end else begin
          cnt_r <= cnt_r + CNT_W'(1'b1);
        end
      end else if (pop) begin
        if (empty_s) begin
          unf_r <= 1'b1;
        end else begin
          ptr_r <= top_idx_s;
          cnt_r <= cnt_r - CNT_W'(1'b1);
        end
      end
    end
  end

endmodule

// File: rtl/next_pc_unit.sv
// Program-counter unit: next-PC source mux, branch decode, stallable PC register
// and return-address stack for calls and returns.
module next_pc_unit
  import mips_pkg::*;
#(
  parameter int          ADDR_W    = ADDR_W_DEFAULT,
  parameter int          RAS_DEPTH = 4,
  parameter logic [31:0] RESET_PC  = 32'd0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [2:0]        pc_sel,
  input  logic              beq,
  input  logic              bne,
  input  logic              zero,
  input  logic              negative,
  input  logic [ADDR_W-1:0] Qs,
  input  logic [25:0]       ins_addr,
  input  logic [15:0]       ins_imm,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] next_pc,
  output logic              taken,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_ovf,
  output logic              ras_unf
);

  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] seq_s;
  logic [ADDR_W-1:0] imm_tgt_s;
  logic [ADDR_W-1:0] j_tgt_s;
  logic [ADDR_W-1:0] ras_top_s;
  logic [ADDR_W-1:0] next_pc_s;
  logic              taken_s;
  logic              br_cond_s;
  logic              push_s;
  logic              pop_s;
  logic              ras_empty_s;
  pc_sel_t           sel_s;

  assign sel_s     = pc_sel_t'(pc_sel);
  assign seq_s     = pc_r + ADDR_W'(1'b1);
  assign imm_tgt_s = ADDR_W'(ins_imm);
  // Zero-extends for wide PCs, truncates the jump field when ADDR_W < 26.
  assign j_tgt_s   = ADDR_W'(ins_addr);
  assign br_cond_s = beq ? zero : (bne & ~zero);

  // Source select; an empty-stack return falls back to the register target.
  always_comb begin
    next_pc_s = seq_s;
    taken_s   = 1'b0;
    push_s    = 1'b0;
    pop_s     = 1'b0;
    case (sel_s)
      PC_SEQ: begin
        next_pc_s = seq_s;
        taken_s   = 1'b0;
      end
      PC_BR: begin
        if (br_cond_s) begin
          next_pc_s = imm_tgt_s;
          taken_s   = 1'b1;
        end else begin
          next_pc_s = seq_s;
          taken_s   = 1'b0;
        end
      end
      PC_J: begin
        next_pc_s = j_tgt_s;
        taken_s   = 1'b1;
      end
      PC_JR: begin
        next_pc_s = Qs;
        taken_s   = 1'b1;
      end
      PC_BN: begin
        if (negative) begin
          next_pc_s = imm_tgt_s;
          taken_s   = 1'b1;
        end else begin
          next_pc_s = seq_s;
          taken_s   = 1'b0;
        end
      end
      PC_CALL: begin
        next_pc_s = j_tgt_s;
        taken_s   = 1'b1;
        push_s    = 1'b1;
      end
      PC_RET: begin
        pop_s   = 1'b1;
        taken_s = 1'b1;
        if (ras_empty_s) begin
          next_pc_s = Qs;
        end else begin
          next_pc_s = ras_top_s;
        end
      end
      default: begin
        next_pc_s = seq_s;
        taken_s   = 1'b0;
      end
    endcase
  end

  // PC register; holds while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r <= ADDR_W'(RESET_PC);
    end else if (!stall) begin
      pc_r <= next_pc_s;
    end
  end

  return_addr_stack #(
    .ADDR_W   (ADDR_W),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk  (clk),
    .rst  (rst),
    .en   (~stall),
    .push (push_s),
    .pop  (pop_s),
    .din  (seq_s),
    .top  (ras_top_s),
    .empty(ras_empty_s),
    .full (ras_full),
    .ovf  (ras_ovf),
    .unf  (ras_unf)
  );

  assign pc        = pc_r;
  assign next_pc   = next_pc_s;
  assign taken     = taken_s;
  assign ras_empty = ras_empty_s;

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed bench for next_pc_unit: a 32-bit instance (RESET_PC 0) and a
// 16-bit instance (RESET_PC 0x100), both with a 4-entry return stack.
module tb_next_pc_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst, stall, beq, bne, zero, negative;
  logic [2:0]  pc_sel;
  logic [31:0] qs;
  logic [25:0] ins_addr;
  logic [15:0] ins_imm;
  logic [31:0] pc, next_pc;
  logic        taken, ras_empty, ras_full, ras_ovf, ras_unf;

  logic        rst1, stall1;
  logic [2:0]  sel1;
  logic [15:0] qs1;
  logic [25:0] ins_addr1;
  logic [15:0] pc1, next_pc1;
  logic        taken1, ras_empty1, ras_full1, ras_ovf1, ras_unf1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  next_pc_unit #(.ADDR_W(32), .RAS_DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .pc_sel(pc_sel), .beq(beq), .bne(bne),
    .zero(zero), .negative(negative), .Qs(qs), .ins_addr(ins_addr), .ins_imm(ins_imm),
    .pc(pc), .next_pc(next_pc), .taken(taken), .ras_empty(ras_empty),
    .ras_full(ras_full), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  next_pc_unit #(.ADDR_W(16), .RAS_DEPTH(4), .RESET_PC(32'h100)) dut16 (
    .clk(clk), .rst(rst1), .stall(stall1), .pc_sel(sel1), .beq(beq), .bne(bne),
    .zero(zero), .negative(negative), .Qs(qs1), .ins_addr(ins_addr1), .ins_imm(ins_imm),
    .pc(pc1), .next_pc(next_pc1), .taken(taken1), .ras_empty(ras_empty1),
    .ras_full(ras_full1), .ras_ovf(ras_ovf1), .ras_unf(ras_unf1)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Jump the 32-bit instance to an arbitrary PC through the register source.
  task automatic goto(input logic [31:0] target);
    pc_sel = PC_JR;
    qs     = target;
    cyc();
  endtask

  // Issue a call on the 32-bit instance and let it commit.
  task automatic call(input logic [25:0] target);
    pc_sel   = PC_CALL;
    ins_addr = target;
    cyc();
  endtask

  task automatic ret(input string tag, input logic [31:0] exp);
    pc_sel = PC_RET;
    cyc();
    check(tag, pc, exp);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; beq = 1'b0; bne = 1'b0; zero = 1'b0; negative = 1'b0;
    pc_sel = PC_SEQ; qs = 32'h0; ins_addr = 26'h0; ins_imm = 16'h0;
    rst1 = 1'b1; stall1 = 1'b0; sel1 = PC_SEQ; qs1 = 16'h0; ins_addr1 = 26'h0;

    #12;
    check("rst_pc", pc, 32'h0);
    check("rst_empty", {31'd0, ras_empty}, 32'd1);
    check("rst_full", {31'd0, ras_full}, 32'd0);
    check("rst_flags", {30'd0, ras_ovf, ras_unf}, 32'd0);
    rst = 1'b0;
    #1;
    check("seq_next", next_pc, 32'h1);
    check("seq_taken", {31'd0, taken}, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      cyc();
      check("seq_pc", pc, 32'(i));
    end

    // Branches
    goto(32'h5);
    pc_sel = PC_BR; beq = 1'b1; zero = 1'b1; ins_imm = 16'h0040;
    #1;
    check("beq_next", next_pc, 32'h40);
    check("beq_taken", {31'd0, taken}, 32'd1);
    cyc();
    check("beq_pc", pc, 32'h40);
    goto(32'h5);
    pc_sel = PC_BR; beq = 1'b1; zero = 1'b0;
    #1;
    check("beq_nt_taken", {31'd0, taken}, 32'd0);
    cyc();
    check("beq_nt_pc", pc, 32'h6);
    beq = 1'b0; bne = 1'b1; zero = 1'b0;
    cyc();
    check("bne_pc", pc, 32'h40);
    beq = 1'b1; bne = 1'b1; zero = 1'b0;
    #1;
    check("beq_prio", next_pc, 32'h41);
    beq = 1'b0; bne = 1'b0;
    pc_sel = PC_BN; negative = 1'b1;
    #1;
    check("bn_t_next", next_pc, 32'h40);
    negative = 1'b0;
    #1;
    check("bn_nt_taken", {31'd0, taken}, 32'd0);
    cyc();
    check("bn_nt_pc", pc, 32'h41);
    pc_sel = 3'd7;
    #1;
    check("rsvd_next", next_pc, 32'h42);

    // Call / return
    goto(32'h10);
    pc_sel = PC_CALL; ins_addr = 26'h200;
    #1;
    check("call_taken", {31'd0, taken}, 32'd1);
    cyc();
    check("call_pc", pc, 32'h200);
    check("call_nonempty", {31'd0, ras_empty}, 32'd0);
    ret("ret_pc", 32'h11);
    check("ret_empty", {31'd0, ras_empty}, 32'd1);
    call(26'h300);
    call(26'h400);
    call(26'h500);
    check("nest_pc", pc, 32'h500);
    check("nest_notfull", {31'd0, ras_full}, 32'd0);
    ret("nest_r1", 32'h401);
    ret("nest_r2", 32'h301);
    ret("nest_r3", 32'h12);
    check("nest_empty", {31'd0, ras_empty}, 32'd1);

    // Overflow / underflow
    goto(32'h1000);
    call(26'h2000);
    call(26'h3000);
    call(26'h4000);
    call(26'h5000);
    check("full4", {31'd0, ras_full}, 32'd1);
    check("noovf4", {31'd0, ras_ovf}, 32'd0);
    call(26'h6000);
    check("ovf5", {31'd0, ras_ovf}, 32'd1);
    check("full5", {31'd0, ras_full}, 32'd1);
    ret("ovf_r1", 32'h5001);
    ret("ovf_r2", 32'h4001);
    ret("ovf_r3", 32'h3001);
    ret("ovf_r4", 32'h2001);
    check("ovf_empty", {31'd0, ras_empty}, 32'd1);
    qs = 32'h77;
    pc_sel = PC_RET;
    #1;
    check("unf_next", next_pc, 32'h77);
    cyc();
    check("unf_pc", pc, 32'h77);
    check("unf_flag", {31'd0, ras_unf}, 32'd1);
    check("ovf_sticky", {31'd0, ras_ovf}, 32'd1);

    // Stall during a call
    stall = 1'b1; pc_sel = PC_CALL; ins_addr = 26'h800;
    #1;
    check("stall_next", next_pc, 32'h800);
    cyc();
    cyc();
    check("stall_pc", pc, 32'h77);
    check("stall_empty", {31'd0, ras_empty}, 32'd1);
    stall = 1'b0;
    cyc();
    check("unstall_pc", pc, 32'h800);
    ret("unstall_ret", 32'h78);
    check("single_push", {31'd0, ras_empty}, 32'd1);
    pc_sel = PC_SEQ;

    // 16-bit instance: reset value, wrap, truncation, async reset
    rst1 = 1'b0;
    #1;
    check("w16_rst_pc", {16'd0, pc1}, 32'h100);
    cyc();
    check("w16_seq", {16'd0, pc1}, 32'h101);
    sel1 = PC_JR; qs1 = 16'hFFFF;
    cyc();
    sel1 = PC_SEQ;
    #1;
    check("w16_wrap_next", {16'd0, next_pc1}, 32'h0);
    cyc();
    check("w16_wrap_pc", {16'd0, pc1}, 32'h0);
    sel1 = PC_J; ins_addr1 = 26'h3FFFFFF;
    #1;
    check("w16_trunc", {16'd0, next_pc1}, 32'hFFFF);
    sel1 = PC_CALL; ins_addr1 = 26'h10;
    cyc();
    ins_addr1 = 26'h20;
    cyc();
    check("w16_call_pc", {16'd0, pc1}, 32'h20);
    check("w16_nonempty", {31'd0, ras_empty1}, 32'd0);
    sel1 = PC_SEQ;
    #3;
    rst1 = 1'b1;
    #1;
    check("w16_async_pc", {16'd0, pc1}, 32'h100);
    check("w16_async_empty", {31'd0, ras_empty1}, 32'd1);
    rst1 = 1'b0;
    cyc();
    check("w16_post_rst", {16'd0, pc1}, 32'h101);
    sel1 = PC_RET; qs1 = 16'h55;
    cyc();
    check("w16_unf_pc", {16'd0, pc1}, 32'h55);
    check("w16_unf", {31'd0, ras_unf1}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
